mat_mul_seq: RTL and testbench

- Sequencer that computes an I×J by J×K floating-point matrix product using one shared external vec_dot unit instead of I*K parallel instances.
- Captures both operand matrices with a valid/ready handshake.
- Issues one row/column dot product per cycle to the vec_dot, collects the results into an I×K result register, and presents the result with a valid/ready handshake.
- Sits between operand producers and the downstream consumer wherever area matters more than throughput.

---
 rtl/mat_mul_seq.sv | 141 ++++++++++++++
 tb/tb_mat_mul_seq.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mat_mul_seq.sv
// Sequencer for an I x J by J x K float matrix product built around one shared,
// fixed-latency external vec_dot unit. Elements are moved bit-exact; no arithmetic here.
module mat_mul_seq #(
    parameter int EXP_WIDTH  = 8,
    parameter int FRAC_WIDTH = 23,
    parameter int I          = 4,
    parameter int J          = 4,
    parameter int K          = 4,
    parameter int DOT_LAT    = 2,
    localparam int W         = 1 + EXP_WIDTH + FRAC_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [I*J*W-1:0]   lhs,
    input  logic [J*K*W-1:0]   rhs,
    output logic [J*W-1:0]     dot_lhs,
    output logic [J*W-1:0]     dot_rhs,
    input  logic [W-1:0]       dot_res,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [I*K*W-1:0]   res,
    output logic               busy
);

    // state | meaning
    // IDLE  | waiting for operand handshake
    // ISSUE | one row/column pair presented to vec_dot per cycle
    // DRAIN | waiting for the last in-flight product to return
    // DONE  | result matrix presented, waiting for consumer
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    localparam int NE = I * K;
    localparam int NW = $clog2(NE + 1);

    state_t            state, state_nxt;
    logic [I*J*W-1:0]  lhs_q;
    logic [J*K*W-1:0]  rhs_q;
    logic [NW-1:0]     n_q;
    logic              pv_q [DOT_LAT];
    logic [NW-1:0]     pn_q [DOT_LAT];

    logic [I*J*W-1:0]  src_lhs;
    logic [J*K*W-1:0]  src_rhs;
    logic [NW-1:0]     sel_n;
    logic [J*W-1:0]    row_sel, col_sel;
    logic              load_ops, last_issue, cap_en;
    logic [NW-1:0]     cap_n;

    assign last_issue = (n_q == NW'(NE - 1));
    assign cap_en     = pv_q[DOT_LAT-1];
    assign cap_n      = pn_q[DOT_LAT-1];
    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = ISSUE;
            ISSUE:   if (last_issue) state_nxt = DRAIN;
            DRAIN:   if (cap_en && cap_n == NW'(NE - 1)) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operands are registered one cycle ahead, so index 0 is loaded straight from the
    // input ports on the accepting edge and later indices from the captured copies.
    always_comb begin
        load_ops = 1'b0;
        sel_n    = '0;
        src_lhs  = lhs_q;
        src_rhs  = rhs_q;
        row_sel  = '0;
        col_sel  = '0;
        if (state == IDLE) begin
            load_ops = in_valid;
            src_lhs  = lhs;
            src_rhs  = rhs;
        end else if (state == ISSUE && !last_issue) begin
            load_ops = 1'b1;
            sel_n    = n_q + NW'(1);
        end
        for (int e = 0; e < NE; e++) begin
            if (sel_n == NW'(e)) begin
                for (int j = 0; j < J; j++) begin
                    row_sel[j*W +: W] = src_lhs[((e / K) * J + j)*W +: W];
                    col_sel[j*W +: W] = src_rhs[(j * K + (e % K))*W +: W];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lhs_q   <= '0;
            rhs_q   <= '0;
            n_q     <= '0;
            dot_lhs <= '0;
            dot_rhs <= '0;
            res     <= '0;
            for (int d = 0; d < DOT_LAT; d++) begin
                pv_q[d] <= 1'b0;
                pn_q[d] <= '0;
            end
        end else begin
            if (state == IDLE && in_valid) begin
                lhs_q <= lhs;
                rhs_q <= rhs;
                n_q   <= '0;
            end else if (state == ISSUE) begin
                n_q <= n_q + NW'(1);
            end
            if (load_ops) begin
                dot_lhs <= row_sel;
                dot_rhs <= col_sel;
            end
            // Stage 0 tags the product on display this cycle; after DOT_LAT stages its
            // result is on dot_res.
            pv_q[0] <= (state == ISSUE);
            pn_q[0] <= n_q;
            for (int d = 1; d < DOT_LAT; d++) begin
                pv_q[d] <= pv_q[d-1];
                pn_q[d] <= pn_q[d-1];
            end
            if (cap_en) begin
                for (int e = 0; e < NE; e++) begin
                    if (cap_n == NW'(e)) res[e*W +: W] <= dot_res;
                end
            end
        end
    end

endmodule

// File: tb/tb_mat_mul_seq.sv
// Bench for mat_mul_seq: several size/latency configurations run side by side, each with
// a float vec_dot model and a reference matrix product computed from the captured operands.
module tb_mat_mul_seq;

    localparam int W    = 32;
    localparam int NCFG = 6;
    localparam int CI [NCFG] = '{2, 2, 4, 4, 4, 1};
    localparam int CJ [NCFG] = '{2, 2, 4, 4, 4, 3};
    localparam int CK [NCFG] = '{2, 3, 4, 4, 4, 1};
    localparam int CD [NCFG] = '{2, 1, 1, 2, 5, 3};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_err  = 0;
    int n_done = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // fp32 <-> real; subnormals flush to zero, narrowing truncates the fraction.
    function automatic real f2r(input logic [31:0] x);
        logic [63:0] b;
        if (x[30:23] == 8'd0) return 0.0;
        b = {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'd0};
        return $bitstoreal(b);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] b;
        logic [10:0] e;
        b = $realtobits(r);
        if (b[62:0] == 63'd0) return {b[63], 31'd0};
        e = b[62:52] - 11'd896;
        return {b[63], e[7:0], b[51:29]};
    endfunction

    function automatic logic [31:0] rnd();
        return {1'($urandom), 8'($urandom_range(134, 120)), 23'($urandom)};
    endfunction

    for (genvar g = 0; g < NCFG; g++) begin : h
        localparam int I  = CI[g];
        localparam int J  = CJ[g];
        localparam int K  = CK[g];
        localparam int DL = CD[g];
        localparam int NE = I * K;
        localparam int RN = (NE > 2) ? 2 : 0;

        logic rst_n, in_valid, in_ready, out_valid, out_ready, busy;
        logic [I*J*W-1:0] lhs;
        logic [J*K*W-1:0] rhs;
        logic [J*W-1:0]   dot_lhs, dot_rhs;
        logic [W-1:0]     dot_res;
        logic [NE*W-1:0]  res;
        logic [W-1:0]     vd [DL];
        logic [W-1:0]     ml [I][J];
        logic [W-1:0]     mr [J][K];
        logic [W-1:0]     cl [I][J];
        logic [W-1:0]     cr [J][K];
        logic [W-1:0]     ex [NE];

        mat_mul_seq #(.EXP_WIDTH(8), .FRAC_WIDTH(23), .I(I), .J(J), .K(K), .DOT_LAT(DL)) dut (
            .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
            .lhs(lhs), .rhs(rhs), .dot_lhs(dot_lhs), .dot_rhs(dot_rhs), .dot_res(dot_res),
            .out_valid(out_valid), .out_ready(out_ready), .res(res), .busy(busy)
        );

        function automatic string tg(input string s);
            return $sformatf("cfg%0d %s", g, s);
        endfunction

        function automatic logic [W-1:0] dotf(input logic [J*W-1:0] a, input logic [J*W-1:0] b);
            real acc = 0.0;
            for (int j = 0; j < J; j++) acc += f2r(a[j*W +: W]) * f2r(b[j*W +: W]);
            return r2f(acc);
        endfunction

        function automatic logic [J*W-1:0] rowv(input int i);
            logic [J*W-1:0] v;
            for (int j = 0; j < J; j++) v[j*W +: W] = cl[i][j];
            return v;
        endfunction

        function automatic logic [J*W-1:0] colv(input int k);
            logic [J*W-1:0] v;
            for (int j = 0; j < J; j++) v[j*W +: W] = cr[j][k];
            return v;
        endfunction

        // vec_dot stand-in: dot of the operands on display, delayed DL clocks.
        always @(posedge clk) begin
            vd[0] <= dotf(dot_lhs, dot_rhs);
            for (int d = 1; d < DL; d++) vd[d] <= vd[d-1];
        end
        assign dot_res = vd[DL-1];

        // mode 0: identity-like lhs, ramp rhs; 1: random; 2: lhs all 2.0, rhs all 1.0
        task automatic prepare(input int mode);
            for (int r = 0; r < I; r++)
                for (int c = 0; c < J; c++) begin
                    ml[r][c] = (mode == 0) ? ((r == c) ? 32'h3F80_0000 : 32'h0) :
                               (mode == 1) ? rnd() : 32'h4000_0000;
                    lhs[(r*J+c)*W +: W] = ml[r][c];
                end
            for (int r = 0; r < J; r++)
                for (int c = 0; c < K; c++) begin
                    mr[r][c] = (mode == 0) ? r2f(real'(r*K + c + 1)) :
                               (mode == 1) ? rnd() : 32'h3F80_0000;
                    rhs[(r*K+c)*W +: W] = mr[r][c];
                end
        endtask

        task automatic run_job(input int stall, input bit early, input int nextmode);
            int c;
            logic [NE*W-1:0] snap;
            cl = ml;
            cr = mr;
            for (int i = 0; i < I; i++)
                for (int k = 0; k < K; k++) ex[i*K+k] = dotf(rowv(i), colv(k));
            in_valid = 1'b1;
            check_eq(tg("in_ready idle"), in_ready, 1);
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = early;
            if (nextmode >= 0) begin
                prepare(nextmode);
                in_valid = 1'b1;
            end
            c = 1;
            while (!out_valid && c < 200) begin
                if (c <= NE) begin
                    check_eq(tg("issue dot_lhs"), dot_lhs, rowv((c - 1) / K));
                    check_eq(tg("issue dot_rhs"), dot_rhs, colv((c - 1) % K));
                end
                check_eq(tg("in_ready/busy while running"), {in_ready, busy}, 2'b01);
                @(negedge clk);
                c++;
            end
            check_eq(tg("latency"), c, NE + DL + 1);
            snap = res;
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                check_eq(tg("stall hold"), {out_valid, in_ready, res == snap}, 3'b101);
            end
            for (int e = 0; e < NE; e++)
                check_eq(tg($sformatf("res[%0d]", e)), res[e*W +: W], ex[e]);
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            check_eq(tg("after out handshake"), {out_valid, in_ready}, 2'b01);
        endtask

        task automatic reset_mid();
            prepare(1);
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            repeat (RN) @(negedge clk);
            check_eq(tg("busy before abort"), busy, 1);
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            check_eq(tg("abort ctl"), {in_ready, out_valid, busy}, 3'b100);
            check_eq(tg("abort dot_lhs"), dot_lhs, 0);
            check_eq(tg("abort dot_rhs"), dot_rhs, 0);
            check_eq(tg("abort res zero"), res == '0, 1);
            repeat (DL + 2) @(negedge clk);
            check_eq(tg("late results ignored"), {res == '0, out_valid, in_ready}, 3'b101);
        endtask

        initial begin
            rst_n     = 1'b0;
            in_valid  = 1'b0;
            out_ready = 1'b0;
            lhs       = '0;
            rhs       = '0;
            repeat (2) @(negedge clk);
            check_eq(tg("reset ctl"), {in_ready, out_valid, busy}, 3'b100);
            check_eq(tg("reset res zero"), res == '0, 1);
            check_eq(tg("reset dot_lhs"), dot_lhs, 0);
            rst_n = 1'b1;
            @(negedge clk);
            prepare(0);
            run_job(10, 1'b0, 2);
            run_job(0, 1'b0, -1);
            reset_mid();
            for (int t = 0; t < 3; t++) begin
                prepare(1);
                run_job((t == 2) ? 3 : 0, t == 1, -1);
            end
            n_done++;
        end
    end

    initial begin
        for (int t = 0; t < 20000 && n_done < NCFG; t++) @(posedge clk);
        check_eq("all configs finished", n_done, NCFG);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
